gameplay_turns: RTL and testbench
=================================

Name: gameplay_turns

Overview:
- Parametrised successor to the single-player gameplay controller. Runs a multi-player, turn-based shot loop: aim with the camera, charge a shot, hand the shot to the ball-physics block over a valid/ready handshake, then wait for the ball to stop.
- Tracks per-player stroke counts, hole-out status and turn rotation.
- Sits between the input debouncers/frame timer and the physics/render blocks. Frame-rate updates are driven by the new_frame strobe.

Parameters:
- N_PLAYERS, 2, number of players (1..8).
- SPEED_W, 16, width of ball_speed.
- ANGLE_W, 16, width of cam_angle/ball_direction; angle wraps modulo 2^ANGLE_W (full turn).
- CHARGE_STEP, 64, speed added per frame while charging.
- SPEED_MAX, 4096, charge saturation value.
- PAN_STEP, 256, angle change per frame while panning.
- MAX_STROKES, 15, stroke cap per player (counter is 4 bits).

Ports:
- clk_in  in  1  system clock (100 MHz).
- rst_in_n  in  1  asynchronous active-low reset.
- new_game  in  1  synchronous start/restart pulse.
- new_frame  in  1  frame strobe; may be held high for many cycles, so it is edge-detected.
- charging_hit  in  1  charge button level.
- camera_pan_left  in  1  pan button level.
- camera_pan_right  in  1  pan button level.
- shot_ready  in  1  physics accepts the shot.
- ball_stopped  in  1  physics reports the ball at rest.
- ball_in_hole  in  1  qualified by ball_stopped.
- shot_valid  out  1  shot offer to physics.
- ball_speed  out  SPEED_W  charged speed.
- ball_direction  out  ANGLE_W  latched shot angle.
- cam_angle  out  ANGLE_W  current camera angle.
- player_idx  out  $clog2(N_PLAYERS) (min 1)  active player.
- stroke_counts  out  4*N_PLAYERS  packed counts; player p occupies bits [4p+3:4p].
- state_out  out  3  FSM state.
- game_over  out  1  all players finished.

Behaviour:
- Reset (async, rst_in_n=0):
  - state IDLE(0); all outputs 0.
  - Finished flags cleared; the new_frame delay register cleared.
- Frame tick: tick = new_frame & ~new_frame_q. It is one cycle per rising edge, and a held-high new_frame produces exactly one tick.
- new_game has priority over every other event, in every state including mid-LAUNCH. Next cycle:
  - state AIM.
  - player_idx 0; stroke_counts, finished flags, ball_speed, ball_direction and cam_angle all cleared.
  - shot_valid 0.
- States:
  - IDLE(0): waits for new_game.
  - AIM(1):
    - On tick: cam_angle += PAN_STEP if only right is pressed; -= PAN_STEP if only left is pressed. Both or neither pressed: no change. Wraps modulo 2^ANGLE_W.
    - charging_hit=1 in any cycle -> CHARGE with ball_speed=0.
  - CHARGE(2):
    - Panning is frozen.
    - On tick with charging_hit=1: ball_speed = min(ball_speed+CHARGE_STEP, SPEED_MAX).
    - charging_hit=0: if ball_speed==0 -> AIM (no shot, no stroke). Otherwise -> LAUNCH with ball_direction<=cam_angle.
    - Release on the same cycle as a tick: release wins and no increment is applied.
  - LAUNCH(3):
    - shot_valid=1; ball_speed and ball_direction are held stable until shot_ready.
    - On shot_valid&shot_ready: stroke[player_idx] += 1, saturating at MAX_STROKES. shot_valid drops next cycle; -> ROLL.
  - ROLL(4): waits for ball_stopped=1, then -> SCORE. ball_speed is held.
  - SCORE(5), exactly one cycle:
    - Player is marked finished if ball_in_hole=1 or stroke==MAX_STROKES.
    - Next player = first unfinished index searching player_idx+1, +2, … modulo N_PLAYERS. The search includes the current player last.
    - Any unfinished player -> AIM with ball_speed=0 and player_idx updated.
    - None unfinished -> DONE.
  - DONE(6): game_over=1; holds all values until new_game.
- state_out encodes the state value directly; codes 7 and any illegal value recover to IDLE.
- ball_in_hole is ignored outside SCORE.
- N_PLAYERS=1: rotation always returns to player 0.

Test Plan:
- Reset then new_game pulse -> state_out 0 with all outputs 0; one cycle after the pulse: state_out 1, player_idx 0, cam_angle 0.
- In AIM from cam_angle 0:
  - camera_pan_left with one new_frame edge held high for 1000 cycles -> cam_angle 16'hFF00, changed exactly once.
  - Both pans pressed over a tick -> still 16'hFF00.
- Hold charging_hit across 70 ticks -> ball_speed 64, 128, …, saturates at 4096.
  - Release -> state 3, shot_valid=1, ball_direction=16'hFF00.
  - shot_ready low for 5 cycles -> outputs stable.
  - shot_ready=1 -> state 4, stroke_counts[3:0]=1.
- Press charging_hit and release before any tick -> state returns 1, ball_speed 0, stroke_counts unchanged, shot_valid never asserted.
- N_PLAYERS=2:
  - P0 shot, then ball_stopped & ball_in_hole -> player_idx 1, state 1.
  - P1 shot, then ball_stopped with ball_in_hole=0 -> player_idx stays 1.
  - P1 holes -> state 6, game_over=1.
- P0 takes 15 shots without holing -> P0 finished at 15 and skipped thereafter.
- new_game asserted during LAUNCH -> next cycle shot_valid=0, state 1, stroke_counts=0.
- rst_in_n low mid-CHARGE -> immediate state 0 and ball_speed 0, without waiting for a clock edge.

Source files
------------

// File: rtl/gameplay_turns.sv
// Multi-player turn-based shot controller.
// Aim, charge, launch over valid/ready, roll, score, rotate.
module gameplay_turns #(
  parameter int N_PLAYERS   = 2,
  parameter int SPEED_W     = 16,
  parameter int ANGLE_W     = 16,
  parameter int CHARGE_STEP = 64,
  parameter int SPEED_MAX   = 4096,
  parameter int PAN_STEP    = 256,
  parameter int MAX_STROKES = 15,
  localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                   clk_in,
  input  logic                   rst_in_n,
  input  logic                   new_game,
  input  logic                   new_frame,
  input  logic                   charging_hit,
  input  logic                   camera_pan_left,
  input  logic                   camera_pan_right,
  input  logic                   shot_ready,
  input  logic                   ball_stopped,
  input  logic                   ball_in_hole,
  output logic                   shot_valid,
  output logic [SPEED_W-1:0]     ball_speed,
  output logic [ANGLE_W-1:0]     ball_direction,
  output logic [ANGLE_W-1:0]     cam_angle,
  output logic [PW-1:0]          player_idx,
  output logic [4*N_PLAYERS-1:0] stroke_counts,
  output logic [2:0]             state_out,
  output logic                   game_over
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AIM    = 3'd1,
    CHARGE = 3'd2,
    LAUNCH = 3'd3,
    ROLL   = 3'd4,
    SCORE  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [SPEED_W:0] S_MAX = (SPEED_W+1)'(SPEED_MAX);
  localparam logic [SPEED_W:0] S_STP = (SPEED_W+1)'(CHARGE_STEP);
  localparam logic [ANGLE_W-1:0] P_STP = ANGLE_W'(PAN_STEP);
  localparam logic [3:0] K_MAX = 4'(MAX_STROKES);

  state_t                 state, state_n;
  logic                   nf_q;
  logic                   tick;
  logic [SPEED_W-1:0]     speed_n;
  logic [ANGLE_W-1:0]     dir_n, cam_n;
  logic [PW-1:0]          pidx_n;
  logic [4*N_PLAYERS-1:0] strk_n;
  logic [N_PLAYERS-1:0]   fin, fin_n;
  logic [3:0]             cur_strk;
  logic [SPEED_W:0]       sum;

  assign tick       = new_frame & ~nf_q;
  assign cur_strk   = stroke_counts[{player_idx, 2'b00} +: 4];
  assign sum        = {1'b0, ball_speed} + S_STP;
  assign shot_valid = (state == LAUNCH);
  assign game_over  = (state == DONE);
  assign state_out  = state;

  // First unfinished player after cur, wrapping, cur itself last.
  function automatic logic [PW:0] pick_next(
    input logic [N_PLAYERS-1:0] f,
    input logic [PW-1:0]        cur
  );
    logic [PW:0] r;
    int          idx;
    r = '0;
    for (int k = N_PLAYERS; k >= 1; k--) begin
      idx = int'(cur) + k;
      if (idx >= N_PLAYERS) idx = idx - N_PLAYERS;
      if (!f[idx]) r = {1'b1, PW'(idx)};
    end
    return r;
  endfunction

  logic [PW:0] nxt;
  assign nxt = pick_next(fin_n, player_idx);

  // State, datapath and score registers.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state          <= IDLE;
      nf_q           <= 1'b0;
      ball_speed     <= '0;
      ball_direction <= '0;
      cam_angle      <= '0;
      player_idx     <= '0;
      stroke_counts  <= '0;
      fin            <= '0;
    end else begin
      state          <= state_n;
      nf_q           <= new_frame;
      ball_speed     <= speed_n;
      ball_direction <= dir_n;
      cam_angle      <= cam_n;
      player_idx     <= pidx_n;
      stroke_counts  <= strk_n;
      fin            <= fin_n;
    end
  end

  // Next-state and next-value decode.
  always_comb begin
    state_n = state;
    speed_n = ball_speed;
    dir_n   = ball_direction;
    cam_n   = cam_angle;
    pidx_n  = player_idx;
    strk_n  = stroke_counts;
    fin_n   = fin;
    if (new_game) begin
      state_n = AIM;
      speed_n = '0;
      dir_n   = '0;
      cam_n   = '0;
      pidx_n  = '0;
      strk_n  = '0;
      fin_n   = '0;
    end else begin
      unique case (state)
        IDLE: ;
        AIM: begin
          if (tick && camera_pan_right && !camera_pan_left)
            cam_n = cam_angle + P_STP;
          else if (tick && camera_pan_left && !camera_pan_right)
            cam_n = cam_angle - P_STP;
          if (charging_hit) begin
            state_n = CHARGE;
            speed_n = '0;
          end
        end
        CHARGE: begin
          if (!charging_hit) begin
            if (ball_speed == '0) begin
              state_n = AIM;
            end else begin
              state_n = LAUNCH;
              dir_n   = cam_angle;
            end
          end else if (tick) begin
            speed_n = (sum > S_MAX) ? S_MAX[SPEED_W-1:0]
                                    : sum[SPEED_W-1:0];
          end
        end
        LAUNCH: begin
          if (shot_ready) begin
            state_n = ROLL;
            if (cur_strk != K_MAX)
              strk_n[{player_idx, 2'b00} +: 4] = cur_strk + 4'd1;
          end
        end
        ROLL: begin
          if (ball_stopped) state_n = SCORE;
        end
        SCORE: begin
          if (ball_in_hole || cur_strk == K_MAX)
            fin_n[player_idx] = 1'b1;
          if (nxt[PW]) begin
            state_n = AIM;
            speed_n = '0;
            pidx_n  = nxt[PW-1:0];
          end else begin
            state_n = DONE;
          end
        end
        DONE: ;
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gameplay_turns.sv
// Directed bench for gameplay_turns, two players.
// Inputs driven and outputs sampled on the falling edge.
module tb_gameplay_turns;

  logic        clk_in = 1'b0;
  logic        rst_in_n;
  logic        new_game, new_frame, charging_hit;
  logic        camera_pan_left, camera_pan_right;
  logic        shot_ready, ball_stopped, ball_in_hole;
  logic        shot_valid;
  logic [15:0] ball_speed, ball_direction, cam_angle;
  logic [0:0]  player_idx;
  logic [7:0]  stroke_counts;
  logic [2:0]  state_out;
  logic        game_over;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  gameplay_turns dut (
    .clk_in           (clk_in),
    .rst_in_n         (rst_in_n),
    .new_game         (new_game),
    .new_frame        (new_frame),
    .charging_hit     (charging_hit),
    .camera_pan_left  (camera_pan_left),
    .camera_pan_right (camera_pan_right),
    .shot_ready       (shot_ready),
    .ball_stopped     (ball_stopped),
    .ball_in_hole     (ball_in_hole),
    .shot_valid       (shot_valid),
    .ball_speed       (ball_speed),
    .ball_direction   (ball_direction),
    .cam_angle        (cam_angle),
    .player_idx       (player_idx),
    .stroke_counts    (stroke_counts),
    .state_out        (state_out),
    .game_over        (game_over)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic shoot();
    charging_hit = 1'b1; step(1);
    new_frame = 1'b1; step(1);
    new_frame = 1'b0; step(1);
    charging_hit = 1'b0; step(1);
    shot_ready = 1'b1; step(1);
    shot_ready = 1'b0;
  endtask

  task automatic settle(input logic hole);
    ball_stopped = 1'b1;
    ball_in_hole = hole;
    step(2);
    ball_stopped = 1'b0;
    ball_in_hole = 1'b0;
  endtask

  initial begin
    rst_in_n = 1'b0;
    new_game = 0; new_frame = 0; charging_hit = 0;
    camera_pan_left = 0; camera_pan_right = 0;
    shot_ready = 0; ball_stopped = 0; ball_in_hole = 0;
    step(2);
    chk("rst_state", 32'(state_out), 0);
    chk("rst_valid", 32'(shot_valid), 0);
    chk("rst_speed", 32'(ball_speed), 0);
    chk("rst_cam", 32'(cam_angle), 0);
    chk("rst_strk", 32'(stroke_counts), 0);
    chk("rst_over", 32'(game_over), 0);
    rst_in_n = 1'b1;
    step(1);
    chk("idle_state", 32'(state_out), 0);

    new_game = 1'b1; step(1);
    new_game = 1'b0;
    chk("ng_state", 32'(state_out), 1);
    chk("ng_pidx", 32'(player_idx), 0);
    chk("ng_cam", 32'(cam_angle), 0);

    camera_pan_left = 1'b1;
    new_frame = 1'b1; step(1);
    chk("pan_once", 32'(cam_angle), 32'hFF00);
    step(999);
    chk("pan_held", 32'(cam_angle), 32'hFF00);
    new_frame = 1'b0; step(1);
    camera_pan_right = 1'b1;
    new_frame = 1'b1; step(1);
    new_frame = 1'b0; step(1);
    chk("pan_both", 32'(cam_angle), 32'hFF00);
    camera_pan_left = 1'b0; camera_pan_right = 1'b0;

    charging_hit = 1'b1; step(1);
    chk("chg_state", 32'(state_out), 2);
    chk("chg_speed0", 32'(ball_speed), 0);
    for (int i = 1; i <= 70; i++) begin
      new_frame = 1'b1; step(1);
      new_frame = 1'b0; step(1);
      chk($sformatf("chg_%0d", i), 32'(ball_speed),
          (i * 64 > 4096) ? 4096 : i * 64);
    end
    chk("chg_cam_frozen", 32'(cam_angle), 32'hFF00);
    charging_hit = 1'b0; step(1);
    chk("l_state", 32'(state_out), 3);
    chk("l_valid", 32'(shot_valid), 1);
    chk("l_dir", 32'(ball_direction), 32'hFF00);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("l_hold_v", 32'(shot_valid), 1);
      chk("l_hold_s", 32'(ball_speed), 4096);
      chk("l_hold_d", 32'(ball_direction), 32'hFF00);
    end
    shot_ready = 1'b1; step(1);
    shot_ready = 1'b0;
    chk("roll_state", 32'(state_out), 4);
    chk("roll_valid", 32'(shot_valid), 0);
    chk("roll_strk", 32'(stroke_counts), 32'h01);
    chk("roll_speed", 32'(ball_speed), 4096);

    settle(1'b1);
    chk("p0_hole_pidx", 32'(player_idx), 1);
    chk("p0_hole_state", 32'(state_out), 1);
    chk("p0_hole_speed", 32'(ball_speed), 0);

    charging_hit = 1'b1; step(1);
    chk("zr_valid", 32'(shot_valid), 0);
    charging_hit = 1'b0; step(1);
    chk("zr_state", 32'(state_out), 1);
    chk("zr_speed", 32'(ball_speed), 0);
    chk("zr_strk", 32'(stroke_counts), 32'h01);

    shoot(); settle(1'b0);
    chk("p1_miss_pidx", 32'(player_idx), 1);
    chk("p1_miss_strk", 32'(stroke_counts), 32'h11);
    shoot(); settle(1'b1);
    chk("done_state", 32'(state_out), 6);
    chk("done_over", 32'(game_over), 1);
    chk("done_strk", 32'(stroke_counts), 32'h21);
    step(3);
    chk("done_hold", 32'(state_out), 6);

    new_game = 1'b1; step(1);
    new_game = 1'b0;
    chk("ng2_strk", 32'(stroke_counts), 0);
    chk("ng2_over", 32'(game_over), 0);
    for (int r = 0; r < 14; r++) begin
      shoot(); settle(1'b0);
      shoot(); settle(1'b0);
    end
    chk("r14_strk", 32'(stroke_counts), 32'hEE);
    chk("r14_pidx", 32'(player_idx), 0);
    shoot(); settle(1'b0);
    chk("p0_cap_strk", 32'(stroke_counts), 32'hEF);
    chk("p0_cap_pidx", 32'(player_idx), 1);
    shoot(); settle(1'b0);
    chk("cap_done", 32'(state_out), 6);
    chk("cap_strk", 32'(stroke_counts), 32'hFF);

    new_game = 1'b1; step(1);
    new_game = 1'b0;
    charging_hit = 1'b1; step(1);
    new_frame = 1'b1; step(1);
    new_frame = 1'b0; step(1);
    charging_hit = 1'b0; step(1);
    chk("ngl_pre", 32'(shot_valid), 1);
    new_game = 1'b1; step(1);
    new_game = 1'b0;
    chk("ngl_valid", 32'(shot_valid), 0);
    chk("ngl_state", 32'(state_out), 1);
    chk("ngl_strk", 32'(stroke_counts), 0);
    chk("ngl_speed", 32'(ball_speed), 0);

    charging_hit = 1'b1; step(1);
    new_frame = 1'b1; step(1);
    new_frame = 1'b0; step(1);
    chk("arst_pre", 32'(ball_speed), 64);
    #2 rst_in_n = 1'b0;
    #1;
    chk("arst_state", 32'(state_out), 0);
    chk("arst_speed", 32'(ball_speed), 0);
    charging_hit = 1'b0;
    step(1);
    rst_in_n = 1'b1;
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
